// File: rtl/shift_seq_pkg.sv
// Shared types and default geometry for the multi-cycle shift sequencer.
// The optional rotate feature is selected by the SHIFT_ROTATE_EN macro.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Reduction used for the zero flag; kept here so every consumer decodes it identically.
  function automatic logic all_zero(input logic [DEF_WIDTH-1:0] value);
    return ~|value;
  endfunction

endpackage

// File: rtl/shift_sequencer_left_shift.sv
// Single-position left-shift datapath stage: moves every bit up by one,
// fills bit 0 with zero and exposes the bit that falls off the top.
module left_shift #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             msb
);

  assign dout = {din[WIDTH-2:0], 1'b0};
  assign msb  = din[WIDTH-1];

endmodule

// File: rtl/shift_sequencer.sv
// Sequences the left_shift stage to perform 0..WIDTH-1 position shifts, one per clock.
// Define SHIFT_ROTATE_EN to compile in rotate-left support selected by req_rotate.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_rotate,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_carry,
  output logic             resp_zero,
  output logic             busy
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] step_s;
  logic [AMT_W-1:0] cnt_r;
  logic             carry_r;
  logic             msb_s;
  logic             load_s;
  logic             shift_en_s;

  left_shift #(
    .WIDTH(WIDTH)
  ) u_left_shift (
    .din (acc_r),
    .dout(shifted_s),
    .msb (msb_s)
  );

`ifdef SHIFT_ROTATE_EN
  logic mode_r;

  // Rotate mode latched at accept; wraps the outgoing msb into bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= 1'b0;
    end else if (load_s) begin
      mode_r <= req_rotate;
    end else begin
      mode_r <= mode_r;
    end
  end

  assign step_s = {shifted_s[WIDTH-1:1], shifted_s[0] | (mode_r & msb_s)};
`else
  logic unused_rotate_s;

  assign unused_rotate_s = req_rotate;
  assign step_s          = shifted_s;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; amt=0 bypasses SHIFT so the counter never has to wrap.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    shift_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          load_s      = 1'b1;
          state_nxt_s = (req_amt == {AMT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_en_s = 1'b1;
        if (cnt_r == {{(AMT_W-1){1'b0}}, 1'b1}) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Accumulator, remaining-count and carry registers; held untouched in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= {AMT_W{1'b0}};
      carry_r <= 1'b0;
    end else if (load_s) begin
      acc_r   <= req_data;
      cnt_r   <= req_amt;
      carry_r <= 1'b0;
    end else if (shift_en_s) begin
      acc_r   <= step_s;
      cnt_r   <= cnt_r - {{(AMT_W-1){1'b0}}, 1'b1};
      carry_r <= msb_s;
    end else begin
      acc_r   <= acc_r;
      cnt_r   <= cnt_r;
      carry_r <= carry_r;
    end
  end

  assign req_ready  = (state_r == ST_IDLE);
  assign resp_valid = (state_r == ST_DONE);
  assign busy       = (state_r == ST_SHIFT) || (state_r == ST_DONE);
  assign resp_data  = acc_r;
  assign resp_carry = carry_r;
  assign resp_zero  = ~|acc_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, reset-abort
// sequence and randomized operations against a double-width arithmetic model.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic [3:0]  req_amt;
  logic        req_rotate;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_carry;
  logic        resp_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  shift_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_rotate(req_rotate),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_carry(resp_carry),
    .resp_zero (resp_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] data;
    int          amt;
    bit          rot;
    int          hold;
    logic [15:0] exp_data;
    bit          exp_carry;
    bit          exp_zero;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: shift inside a 32-bit word; the upper half holds what fell off the top.
  function automatic logic [15:0] model_data(input logic [15:0] d, input int amt, input bit rot);
    logic [31:0] w;
    w = {16'h0000, d} << amt;
    if (ROT_EN && rot) return w[15:0] | w[31:16];
    return w[15:0];
  endfunction

  function automatic bit model_carry(input logic [15:0] d, input int amt);
    logic [31:0] w;
    w = {16'h0000, d} << amt;
    return (amt == 0) ? 1'b0 : w[16];
  endfunction

  task automatic run_op(input string tag, input logic [15:0] d, input int amt, input bit rot,
                        input int hold, input logic [15:0] ed, input bit ec, input bit ez,
                        input int elat);
    int n;
    int lat;
    n = 0;
    while (!req_ready && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_data   = d;
    req_amt    = amt[3:0];
    req_rotate = rot;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_data"}, {16'd0, resp_data}, {16'd0, ed});
    check({tag, "_carry"}, {31'd0, resp_carry}, {31'd0, ec});
    check({tag, "_zero"}, {31'd0, resp_zero}, {31'd0, ez});
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req_valid = 1'b1;
        req_data  = ~d;
        req_amt   = 4'd0;
      end
      tick();
      req_valid = 1'b0;
      check({tag, "_hold_data"}, {16'd0, resp_data}, {16'd0, ed});
      check({tag, "_hold_carry"}, {31'd0, resp_carry}, {31'd0, ec});
      check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_rdy"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_resp_data"}, {16'd0, resp_data}, 32'd0);
    check({tag, "_resp_carry"}, {31'd0, resp_carry}, 32'd0);
    check({tag, "_resp_zero"}, {31'd0, resp_zero}, 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    int seen;
    logic [15:0] rd;
    int ra;
    bit rr;
    int rh;

    vecs[0] = '{16'h0001, 4,  1'b0, 0, 16'h0010, 1'b0, 1'b0, 5};
    vecs[1] = '{16'h0001, 15, 1'b0, 0, 16'h8000, 1'b0, 1'b0, 16};
    vecs[2] = '{16'h8001, 1,  1'b0, 0, 16'h0002, 1'b1, 1'b0, 2};
    vecs[3] = '{16'h1234, 0,  1'b0, 0, 16'h1234, 1'b0, 1'b0, 1};
    vecs[4] = '{16'h8000, 1,  1'b0, 0, 16'h0000, 1'b1, 1'b1, 2};
    vecs[5] = '{16'h00FF, 8,  1'b0, 3, 16'hFF00, 1'b0, 1'b0, 9};
    vecs[6] = '{16'h8001, 1,  1'b1, 0, ROT_EN ? 16'h0003 : 16'h0002, 1'b1, 1'b0, 2};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_data   = 16'h0000;
    req_amt    = 4'd0;
    req_rotate = 1'b0;
    resp_ready = 1'b0;
    tick();
    tick();
    check_reset_state("por");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].rot, vecs[i].hold,
             vecs[i].exp_data, vecs[i].exp_carry, vecs[i].exp_zero, vecs[i].exp_lat);
    end

    // Abort a long operation with reset, then confirm a fresh request works.
    req_valid = 1'b1;
    req_data  = 16'hFFFF;
    req_amt   = 4'd15;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    check("midrst_no_resp", seen, 0);
    run_op("after_rst", 16'h0003, 2, 1'b0, 0, 16'h000C, 1'b0, 1'b0, 3);

    for (int i = 0; i < 40; i++) begin
      rd = 16'($urandom);
      ra = int'($urandom_range(0, 15));
      rr = 1'($urandom_range(0, 1));
      rh = int'($urandom_range(0, 2));
      run_op($sformatf("rnd%0d", i), rd, ra, rr, rh, model_data(rd, ra, rr),
             model_carry(rd, ra), model_data(rd, ra, rr) == 16'h0000, ra + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
